voice_allocator: RTL and testbench



---
 rtl/synth_pkg.sv | 66 ++++++
 rtl/note_freq.sv | 47 ++++
 rtl/voice_allocator.sv | 171 +++++++++++++++++
 tb/tb_voice_allocator.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// rtl/synth_pkg.sv - shared types, ratio table and scancode decode for the voice allocator
//
// Contents:
//   RATIO_Q16    : just-intonation ratios for semitones 0..12, unsigned Q2.16
//   key_to_semi  : PS/2 scancode (bit 8 = extended) -> {valid, semitone}
//   KEY_OCT_DOWN / KEY_OCT_UP : octave shift keys (Z / X)
//   voice_t      : per-voice record (note tag, active flag, allocation stamp)
//   state_t      : allocator FSM states
package synth_pkg;

  localparam int RATIO_W   = 18;  // Q2.16: ratio 2 needs the 18th bit
  localparam int NUM_SEMI  = 13;
  localparam int OCT_TAG_W = 5;   // octave part of the note tag, covers any OCT_MAX up to 31

  localparam logic [8:0] KEY_OCT_DOWN = 9'h01A;
  localparam logic [8:0] KEY_OCT_UP   = 9'h022;

  // round(ratio * 65536): 1, 16/15, 9/8, 6/5, 5/4, 4/3, 45/32, 3/2, 8/5, 5/3, 16/9, 15/8, 2
  localparam logic [RATIO_W-1:0] RATIO_Q16 [NUM_SEMI] = '{
    18'd65536,  18'd69905,  18'd73728,  18'd78643,  18'd81920,
    18'd87381,  18'd92160,  18'd98304,  18'd104858, 18'd109227,
    18'd116508, 18'd122880, 18'd131072
  };

  typedef struct packed {
    logic       valid;
    logic [3:0] semi;
  } semi_t;

  typedef struct packed {
    logic [3:0]           semi;
    logic [OCT_TAG_W-1:0] oct;
    logic                 active;
    logic [15:0]          stamp;
  } voice_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_COMMIT
  } state_t;

  function automatic semi_t key_to_semi(input logic [8:0] code);
    semi_t r;
    r = '0;
    r.valid = 1'b1;
    case (code)
      9'h015:  r.semi = 4'd0;
      9'h016:  r.semi = 4'd1;
      9'h01D:  r.semi = 4'd2;
      9'h026:  r.semi = 4'd3;
      9'h024:  r.semi = 4'd4;
      9'h02D:  r.semi = 4'd5;
      9'h02E:  r.semi = 4'd6;
      9'h02C:  r.semi = 4'd7;
      9'h036:  r.semi = 4'd8;
      9'h035:  r.semi = 4'd9;
      9'h03C:  r.semi = 4'd10;
      9'h03D:  r.semi = 4'd11;
      9'h043:  r.semi = 4'd12;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/note_freq.sv
// rtl/note_freq.sv - registered BASE_HZ x ratio product with octave shift and saturation
//
// Ports:
//   clk_audio, reset_n : clock, asynchronous active-low reset
//   load               : capture a new note (semi, oct) this cycle
//   semi               : semitone 0..12
//   oct                : octave shift applied to the captured product
//   freq               : Q(FREQ_W-16).16 Hz, valid the cycle after load
module note_freq
  import synth_pkg::*;
#(
  parameter int FREQ_W  = 32,
  parameter int BASE_HZ = 110,
  parameter int OCT_MAX = 4,
  parameter int OCT_W   = 3
) (
  input  logic              clk_audio,
  input  logic              reset_n,
  input  logic              load,
  input  logic [3:0]        semi,
  input  logic [OCT_W-1:0]  oct,
  output logic [FREQ_W-1:0] freq
);

  localparam int PROD_W = 32 + RATIO_W;
  // Wide enough for the largest shift and for a non-empty overflow slice.
  localparam int WIDE_W = ((PROD_W + OCT_MAX > FREQ_W) ? PROD_W + OCT_MAX : FREQ_W) + 1;

  logic [PROD_W-1:0] prod_q;
  logic [OCT_W-1:0]  oct_q;
  logic [WIDE_W-1:0] wide;

  // Integer Hz times a Q2.16 ratio is already Q.16 Hz; no rescaling needed.
  always_ff @(posedge clk_audio or negedge reset_n) begin
    if (!reset_n) begin
      prod_q <= '0;
      oct_q  <= '0;
    end else if (load) begin
      prod_q <= PROD_W'(BASE_HZ) * PROD_W'(RATIO_Q16[semi]);
      oct_q  <= oct;
    end
  end

  assign wide = WIDE_W'(prod_q) << oct_q;
  assign freq = (|wide[WIDE_W-1:FREQ_W]) ? '1 : wide[FREQ_W-1:0];

endmodule

// File: rtl/voice_allocator.sv
// rtl/voice_allocator.sv - polyphonic note allocator with oldest-voice stealing
//
// Ports:
//   clk_audio, reset_n         : clock, asynchronous active-low reset
//   key_valid/key_pressed/key_code : decoded PS/2 event (make=1, bit 8 = extended)
//   ready                      : an event can be accepted this cycle
//   drop                       : pulse, an event arrived while busy and was discarded
//   frequencies                : NUM_VOICES x FREQ_W, voice i at [i*FREQ_W +: FREQ_W]
//   voice_volumes              : NUM_VOICES x 32, 0 = silent
//   octave                     : current octave shift
module voice_allocator
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = 8,
  parameter int FREQ_W     = 32,
  parameter int BASE_HZ    = 110,
  parameter int OCT_MAX    = 4,
  parameter int VOLUME_ON  = 1 << 20,
  localparam int OCT_W     = $clog2(OCT_MAX + 1)
) (
  input  logic                         clk_audio,
  input  logic                         reset_n,
  input  logic                         key_valid,
  input  logic                         key_pressed,
  input  logic [8:0]                   key_code,
  output logic                         ready,
  output logic                         drop,
  output logic [NUM_VOICES*FREQ_W-1:0] frequencies,
  output logic [NUM_VOICES*32-1:0]     voice_volumes,
  output logic [OCT_W-1:0]             octave
);

  localparam int IDX_W = $clog2(NUM_VOICES);

  state_t               state;
  logic [IDX_W-1:0]     scan_idx;
  logic                 pressed_q;
  logic [3:0]           semi_q;
  logic [OCT_TAG_W-1:0] oct_q;
  logic                 match_found, free_found, old_found;
  logic [IDX_W-1:0]     match_idx, free_idx, old_idx;
  logic [15:0]          old_age;
  logic [15:0]          seq;

  voice_t               voices [NUM_VOICES];
  logic [FREQ_W-1:0]    freq_q [NUM_VOICES];
  logic [31:0]          vol_q  [NUM_VOICES];

  semi_t                key_semi;
  logic                 accept;
  logic [FREQ_W-1:0]    note_hz;
  voice_t               cur;
  logic [15:0]          cur_age;
  logic                 cur_match;
  logic [IDX_W-1:0]     tgt;

  assign key_semi  = key_to_semi(key_code);
  assign accept    = key_valid && (state == ST_IDLE) && key_semi.valid;

  // Voice under examination during SCAN; age wraps modulo 2^16 with seq.
  assign cur       = voices[scan_idx];
  assign cur_age   = seq - cur.stamp;
  assign cur_match = cur.active && (cur.semi == semi_q) && (cur.oct == oct_q);
  assign tgt       = free_found ? free_idx : old_idx;

  // The product register loads with the event and is ready during the first SCAN cycle.
  note_freq #(
    .FREQ_W  (FREQ_W),
    .BASE_HZ (BASE_HZ),
    .OCT_MAX (OCT_MAX),
    .OCT_W   (OCT_W)
  ) u_note_freq (
    .clk_audio (clk_audio),
    .reset_n   (reset_n),
    .load      (accept),
    .semi      (key_semi.semi),
    .oct       (octave),
    .freq      (note_hz)
  );

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_flat
    assign frequencies[g*FREQ_W +: FREQ_W] = freq_q[g];
    assign voice_volumes[g*32 +: 32]       = vol_q[g];
  end

  always_ff @(posedge clk_audio or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      ready       <= 1'b1;
      drop        <= 1'b0;
      octave      <= '0;
      seq         <= '0;
      scan_idx    <= '0;
      pressed_q   <= 1'b0;
      semi_q      <= '0;
      oct_q       <= '0;
      match_found <= 1'b0;
      free_found  <= 1'b0;
      old_found   <= 1'b0;
      match_idx   <= '0;
      free_idx    <= '0;
      old_idx     <= '0;
      old_age     <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        voices[i] <= '0;
        freq_q[i] <= '0;
        vol_q[i]  <= '0;
      end
    end else begin
      drop <= key_valid && !ready;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            pressed_q   <= key_pressed;
            semi_q      <= key_semi.semi;
            oct_q       <= OCT_TAG_W'(octave);
            scan_idx    <= '0;
            match_found <= 1'b0;
            free_found  <= 1'b0;
            old_found   <= 1'b0;
            ready       <= 1'b0;
            state       <= ST_SCAN;
          end else if (key_valid && key_pressed && key_code == KEY_OCT_DOWN) begin
            if (octave != '0) octave <= octave - OCT_W'(1);
          end else if (key_valid && key_pressed && key_code == KEY_OCT_UP) begin
            if (octave != OCT_W'(OCT_MAX)) octave <= octave + OCT_W'(1);
          end
        end
        ST_SCAN: begin
          if (cur_match && !match_found) begin
            match_found <= 1'b1;
            match_idx   <= scan_idx;
          end
          if (!cur.active && !free_found) begin
            free_found <= 1'b1;
            free_idx   <= scan_idx;
          end
          // Strict compare keeps the lowest index on equal ages.
          if (cur.active && (!old_found || cur_age > old_age)) begin
            old_found <= 1'b1;
            old_idx   <= scan_idx;
            old_age   <= cur_age;
          end
          if (scan_idx == IDX_W'(NUM_VOICES - 1)) state <= ST_COMMIT;
          else scan_idx <= scan_idx + IDX_W'(1);
        end
        ST_COMMIT: begin
          if (pressed_q) begin
            // An already-sounding identical note is not retriggered.
            if (!match_found) begin
              voices[tgt] <= '{semi: semi_q, oct: oct_q, active: 1'b1, stamp: seq};
              freq_q[tgt] <= note_hz;
              vol_q[tgt]  <= 32'(VOLUME_ON);
              seq         <= seq + 16'd1;
            end
          end else if (match_found) begin
            voices[match_idx].active <= 1'b0;
            vol_q[match_idx]         <= '0;
          end
          ready <= 1'b1;
          state <= ST_IDLE;
        end
        default: begin
          ready <= 1'b1;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// tb/tb_voice_allocator.sv - self-checking bench for voice_allocator
module tb_voice_allocator;

  localparam int NV     = 4;
  localparam int FW     = 32;
  localparam int VOL_ON = 1 << 20;

  logic              clk_audio = 1'b0;
  logic              reset_n = 1'b0;
  logic              key_valid = 1'b0;
  logic              key_pressed = 1'b0;
  logic [8:0]        key_code = '0;
  logic              ready;
  logic              drop;
  logic [NV*FW-1:0]  frequencies;
  logic [NV*32-1:0]  voice_volumes;
  logic [2:0]        octave;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [31:0] m_freq [NV];
  logic [31:0] m_vol [NV];
  bit          m_act [NV];
  int          m_semi [NV];
  int          m_oct [NV];
  int          m_stamp [NV];
  int          m_seq;
  int          m_octave;

  int codes [13] = '{'h015, 'h016, 'h01D, 'h026, 'h024, 'h02D, 'h02E, 'h02C,
                     'h036, 'h035, 'h03C, 'h03D, 'h043};
  int rnum  [13] = '{1, 16, 9, 6, 5, 4, 45, 3, 8, 5, 16, 15, 2};
  int rden  [13] = '{1, 15, 8, 5, 4, 3, 32, 2, 5, 3, 9, 8, 1};

  voice_allocator #(
    .NUM_VOICES (NV),
    .FREQ_W     (FW),
    .BASE_HZ    (110),
    .OCT_MAX    (4),
    .VOLUME_ON  (VOL_ON)
  ) dut (
    .clk_audio     (clk_audio),
    .reset_n       (reset_n),
    .key_valid     (key_valid),
    .key_pressed   (key_pressed),
    .key_code      (key_code),
    .ready         (ready),
    .drop          (drop),
    .frequencies   (frequencies),
    .voice_volumes (voice_volumes),
    .octave        (octave)
  );

  always #5 clk_audio = ~clk_audio;

  function automatic int semi_of(input int code);
    for (int i = 0; i < 13; i++) if (codes[i] == code) return i;
    return -1;
  endfunction

  function automatic logic [31:0] exp_freq(input int s, input int o);
    longint r, f;
    r = (longint'(rnum[s]) * 131072 + rden[s]) / (2 * rden[s]);
    f = (110 * r) << o;
    if (f > 64'hFFFFFFFF) return 32'hFFFFFFFF;
    return f[31:0];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NV; i++) begin
      m_freq[i] = '0; m_vol[i] = '0; m_act[i] = 0;
      m_semi[i] = 0; m_oct[i] = 0; m_stamp[i] = 0;
    end
    m_seq = 0;
    m_octave = 0;
  endtask

  task automatic model_event(input bit p, input int code);
    int s, hit, tgt, age, best;
    s = semi_of(code);
    if (s >= 0) begin
      hit = -1;
      for (int i = 0; i < NV; i++)
        if (hit < 0 && m_act[i] && m_semi[i] == s && m_oct[i] == m_octave) hit = i;
      if (p) begin
        if (hit < 0) begin
          tgt = -1;
          for (int i = 0; i < NV; i++) if (tgt < 0 && !m_act[i]) tgt = i;
          if (tgt < 0) begin
            best = -1;
            for (int i = 0; i < NV; i++) begin
              age = (m_seq - m_stamp[i]) & 65535;
              if (age > best) begin best = age; tgt = i; end
            end
          end
          m_freq[tgt] = exp_freq(s, m_octave);
          m_vol[tgt] = VOL_ON;
          m_act[tgt] = 1;
          m_semi[tgt] = s;
          m_oct[tgt] = m_octave;
          m_stamp[tgt] = m_seq;
          m_seq = (m_seq + 1) & 65535;
        end
      end else if (hit >= 0) begin
        m_vol[hit] = '0;
        m_act[hit] = 0;
      end
    end else if (p && code == 'h01A) begin
      if (m_octave > 0) m_octave--;
    end else if (p && code == 'h022) begin
      if (m_octave < 4) m_octave++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk_audio);
    reset_n = 1'b0;
    key_valid = 1'b0;
    repeat (2) @(negedge clk_audio);
    reset_n = 1'b1;
    model_reset();
  endtask

  // One-cycle strobe; returns at the falling edge after the sampling edge.
  task automatic strobe(input bit p, input int code);
    @(negedge clk_audio);
    key_valid = 1'b1;
    key_pressed = p;
    key_code = 9'(code);
    @(posedge clk_audio);
    @(negedge clk_audio);
    key_valid = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (ready !== 1'b1 && n < 50) begin
      @(posedge clk_audio);
      @(negedge clk_audio);
      n++;
    end
    if (ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL wait_ready: ready=%b still low after %0d cycles, required 1", ready, n);
    end
  endtask

  task automatic do_event(input bit p, input int code, output int n);
    strobe(p, code);
    wait_ready(n);
    model_event(p, code);
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < NV; i++) begin
      checks++;
      if (frequencies[i*FW +: FW] !== 32'd0 || voice_volumes[i*32 +: 32] !== 32'd0) begin
        errors++;
        $display("FAIL reset_voice%0d: freq=%h vol=%h required 0/0", i,
                 frequencies[i*FW +: FW], voice_volumes[i*32 +: 32]);
      end
    end
    checks++;
    if (ready !== 1'b1 || drop !== 1'b0 || octave !== 3'd0) begin
      errors++;
      $display("FAIL reset_ctrl: ready=%b drop=%b octave=%0d required 1/0/0", ready, drop, octave);
    end
  endtask

  task automatic test_base_pitch();
    int n;
    do_reset();
    do_event(1, 'h015, n);
    checks++;
    if (n + 1 != NV + 2) begin
      errors++;
      $display("FAIL base_latency: ready back after %0d cycles, required %0d", n + 1, NV + 2);
    end
    checks++;
    if (frequencies[0 +: FW] !== 32'h006E0000 || voice_volumes[0 +: 32] !== 32'(VOL_ON)) begin
      errors++;
      $display("FAIL base_voice0: freq=%h vol=%h required 006e0000/%h",
               frequencies[0 +: FW], voice_volumes[0 +: 32], VOL_ON);
    end
    for (int i = 1; i < NV; i++) begin
      checks++;
      if (frequencies[i*FW +: FW] !== 32'd0 || voice_volumes[i*32 +: 32] !== 32'd0) begin
        errors++;
        $display("FAIL base_other%0d: freq=%h vol=%h required 0/0", i,
                 frequencies[i*FW +: FW], voice_volumes[i*32 +: 32]);
      end
    end
  endtask

  task automatic test_interval_octave();
    int n;
    do_reset();
    do_event(1, 'h022, n);
    checks++;
    if (octave !== 3'd1 || n != 0) begin
      errors++;
      $display("FAIL octave_up: octave=%0d wait=%0d required 1/0", octave, n);
    end
    do_event(1, 'h01D, n);
    checks++;
    if (frequencies[0 +: FW] !== 32'd16220160) begin
      errors++;
      $display("FAIL interval_freq: got %0d required 16220160", frequencies[0 +: FW]);
    end
    do_event(1, 'h01A, n);
    do_event(1, 'h01A, n);
    checks++;
    if (octave !== 3'd0) begin
      errors++;
      $display("FAIL octave_floor: octave=%0d required 0", octave);
    end
    for (int k = 0; k < 6; k++) do_event(1, 'h022, n);
    checks++;
    if (octave !== 3'd4 || 32'(m_octave) !== 32'(octave)) begin
      errors++;
      $display("FAIL octave_ceiling: octave=%0d required 4", octave);
    end
  endtask

  task automatic test_duplicate_release();
    int n;
    do_reset();
    do_event(1, 'h015, n);
    do_event(1, 'h015, n);
    checks++;
    if (voice_volumes[0 +: 32] !== 32'(VOL_ON) || voice_volumes[32 +: 32] !== 32'd0) begin
      errors++;
      $display("FAIL dup_make: vol0=%h vol1=%h required %h/0",
               voice_volumes[0 +: 32], voice_volumes[32 +: 32], VOL_ON);
    end
    for (int k = 0; k < 2; k++) begin
      do_event(0, 'h015, n);
      checks++;
      if (voice_volumes[0 +: 32] !== 32'd0 || frequencies[0 +: FW] !== 32'h006E0000) begin
        errors++;
        $display("FAIL release%0d: vol0=%h freq0=%h required 0/006e0000",
                 k, voice_volumes[0 +: 32], frequencies[0 +: FW]);
      end
    end
  endtask

  task automatic test_steal();
    int n;
    int seq5 [5] = '{'h015, 'h016, 'h01D, 'h026, 'h024};
    do_reset();
    for (int k = 0; k < 5; k++) do_event(1, seq5[k], n);
    checks++;
    if (frequencies[0 +: FW] !== 32'd9011200 || voice_volumes[0 +: 32] !== 32'(VOL_ON)) begin
      errors++;
      $display("FAIL steal_voice0: freq=%0d vol=%h required 9011200/%h",
               frequencies[0 +: FW], voice_volumes[0 +: 32], VOL_ON);
    end
    for (int i = 1; i < NV; i++) begin
      checks++;
      if (frequencies[i*FW +: FW] !== m_freq[i] || voice_volumes[i*32 +: 32] !== m_vol[i]) begin
        errors++;
        $display("FAIL steal_other%0d: freq=%h vol=%h required %h/%h", i,
                 frequencies[i*FW +: FW], voice_volumes[i*32 +: 32], m_freq[i], m_vol[i]);
      end
    end
  endtask

  task automatic test_drop();
    int n;
    do_reset();
    strobe(1, 'h015);
    key_valid = 1'b1;
    key_pressed = 1'b1;
    key_code = 9'h016;
    @(posedge clk_audio);
    @(negedge clk_audio);
    key_valid = 1'b0;
    checks++;
    if (drop !== 1'b1) begin
      errors++;
      $display("FAIL drop_pulse: drop=%b required 1", drop);
    end
    @(posedge clk_audio);
    @(negedge clk_audio);
    checks++;
    if (drop !== 1'b0) begin
      errors++;
      $display("FAIL drop_single: drop=%b required 0", drop);
    end
    wait_ready(n);
    model_event(1, 'h015);
    checks++;
    if (voice_volumes[32 +: 32] !== 32'd0 || frequencies[0 +: FW] !== 32'h006E0000) begin
      errors++;
      $display("FAIL drop_effect: vol1=%h freq0=%h required 0/006e0000",
               voice_volumes[32 +: 32], frequencies[0 +: FW]);
    end
  endtask

  task automatic test_reset_mid_scan();
    int n;
    do_reset();
    do_event(1, 'h022, n);
    do_event(1, 'h015, n);
    strobe(1, 'h016);
    @(posedge clk_audio);
    @(posedge clk_audio);
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (frequencies !== '0 || voice_volumes !== '0 || octave !== 3'd0 || drop !== 1'b0) begin
      errors++;
      $display("FAIL midscan_clear: freq=%h vol=%h octave=%0d drop=%b required all 0",
               frequencies, voice_volumes, octave, drop);
    end
    @(negedge clk_audio);
    reset_n = 1'b1;
    model_reset();
    @(negedge clk_audio);
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL midscan_ready: ready=%b required 1", ready);
    end
    do_event(1, 'h016, n);
    checks++;
    if (frequencies[0 +: FW] !== 32'd7689550 || voice_volumes[0 +: 32] !== 32'(VOL_ON)) begin
      errors++;
      $display("FAIL midscan_next: freq0=%0d vol0=%h required 7689550/%h",
               frequencies[0 +: FW], voice_volumes[0 +: 32], VOL_ON);
    end
  endtask

  task automatic test_random();
    int n, r, code, expn;
    bit p;
    do_reset();
    for (int k = 0; k < 60; k++) begin
      r = $urandom_range(0, 16);
      if (r < 13) code = codes[r];
      else if (r == 13) code = 'h01A;
      else if (r == 14) code = 'h022;
      else if (r == 15) code = 'h01C;
      else code = 'h115;
      p = ($urandom_range(0, 9) < 7);
      expn = (semi_of(code) >= 0) ? NV + 1 : 0;
      do_event(p, code, n);
      checks++;
      if (n != expn || 32'(octave) !== 32'(m_octave)) begin
        errors++;
        $display("FAIL rand%0d_ctrl: code=%h wait=%0d octave=%0d required %0d/%0d",
                 k, code, n, octave, expn, m_octave);
      end
      for (int i = 0; i < NV; i++) begin
        checks++;
        if (frequencies[i*FW +: FW] !== m_freq[i] || voice_volumes[i*32 +: 32] !== m_vol[i]) begin
          errors++;
          $display("FAIL rand%0d_voice%0d: freq=%h vol=%h required %h/%h", k, i,
                   frequencies[i*FW +: FW], voice_volumes[i*32 +: 32], m_freq[i], m_vol[i]);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_base_pitch();
    test_interval_octave();
    test_duplicate_release();
    test_steal();
    test_drop();
    test_reset_mid_scan();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
